// File: rtl/anabellek_hakem.sv
// Two-port arbiter sharing one main-memory controller between the I-cache and D-cache.
// Optional build macro ANABELLEK_HAKEM_RR_EN selects round-robin instead of fixed D-cache priority.
module anabellek_hakem (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         b_istek_i,
    input  logic [31:0]  b_adres_i,
    output logic         b_musait_o,
    output logic         b_hazir_o,
    output logic [127:0] b_obek_o,
    input  logic         v_istek_i,
    input  logic [31:0]  v_adres_i,
    input  logic         v_yaz_i,
    input  logic [127:0] v_yaz_obek_i,
    output logic         v_musait_o,
    output logic         v_hazir_o,
    output logic [127:0] v_obek_o,
    input  logic         anabellek_musait_i,
    input  logic         anabellek_hazir_i,
    input  logic [127:0] anabellek_obek_i,
    output logic         anabellek_istek_o,
    output logic [31:0]  anabellek_adres_o,
    output logic         anabellek_oku_o,
    output logic         anabellek_yaz_o,
    output logic [127:0] anabellek_yaz_obek_o,
    output logic [1:0]   durum_o
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTE  = 2'd1,
        CEVAP = 2'd2
    } durum_t;

    durum_t       durum_q;
    logic         sahip_v_q;
    logic         b_hazir_q;
    logic         v_hazir_q;
    logic [127:0] b_obek_q;
    logic [127:0] v_obek_q;
    logic         istek_q;
    logic         oku_q;
    logic         yaz_q;
    logic [31:0]  adres_q;
    logic [127:0] yaz_obek_q;
`ifdef ANABELLEK_HAKEM_RR_EN
    logic         son_v_q;
`endif

    logic talep;
    logic v_kazanir;
    logic unused_adres_bits;

    assign unused_adres_bits = ^{b_adres_i[3:0], v_adres_i[3:0]};
    assign talep = b_istek_i | v_istek_i;

    always_comb begin
        v_kazanir = v_istek_i;
`ifdef ANABELLEK_HAKEM_RR_EN
        // On a tie the port that was not served last wins.
        if (b_istek_i && v_istek_i) begin
            v_kazanir = ~son_v_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q    <= BOSTA;
            sahip_v_q  <= 1'b0;
            b_hazir_q  <= 1'b0;
            v_hazir_q  <= 1'b0;
            b_obek_q   <= '0;
            v_obek_q   <= '0;
            istek_q    <= 1'b0;
            oku_q      <= 1'b0;
            yaz_q      <= 1'b0;
            adres_q    <= '0;
            yaz_obek_q <= '0;
`ifdef ANABELLEK_HAKEM_RR_EN
            son_v_q    <= 1'b1;
`endif
        end else begin
            case (durum_q)
                BOSTA: begin
                    b_hazir_q <= 1'b0;
                    v_hazir_q <= 1'b0;
                    if (anabellek_musait_i && talep) begin
                        sahip_v_q <= v_kazanir;
                        adres_q   <= v_kazanir ? {v_adres_i[31:4], 4'b0000}
                                               : {b_adres_i[31:4], 4'b0000};
                        yaz_q     <= v_kazanir & v_yaz_i;
                        oku_q     <= ~(v_kazanir & v_yaz_i);
                        istek_q   <= 1'b1;
                        if (v_kazanir) begin
                            yaz_obek_q <= v_yaz_obek_i;
                        end
`ifdef ANABELLEK_HAKEM_RR_EN
                        son_v_q   <= v_kazanir;
`endif
                        durum_q   <= ISTE;
                    end
                end
                ISTE: begin
                    if (anabellek_hazir_i) begin
                        istek_q <= 1'b0;
                        oku_q   <= 1'b0;
                        yaz_q   <= 1'b0;
                        if (sahip_v_q) begin
                            v_obek_q  <= anabellek_obek_i;
                            v_hazir_q <= 1'b1;
                        end else begin
                            b_obek_q  <= anabellek_obek_i;
                            b_hazir_q <= 1'b1;
                        end
                        durum_q <= CEVAP;
                    end
                end
                CEVAP: begin
                    b_hazir_q <= 1'b0;
                    v_hazir_q <= 1'b0;
                    durum_q   <= BOSTA;
                end
                default: begin
                    b_hazir_q <= 1'b0;
                    v_hazir_q <= 1'b0;
                    istek_q   <= 1'b0;
                    oku_q     <= 1'b0;
                    yaz_q     <= 1'b0;
                    durum_q   <= BOSTA;
                end
            endcase
        end
    end

    // Acceptance is combinational so a requester can react in the same cycle.
    assign b_musait_o = (durum_q == BOSTA) & anabellek_musait_i;
    assign v_musait_o = (durum_q == BOSTA) & anabellek_musait_i;

    assign b_hazir_o            = b_hazir_q;
    assign v_hazir_o            = v_hazir_q;
    assign b_obek_o             = b_obek_q;
    assign v_obek_o             = v_obek_q;
    assign anabellek_istek_o    = istek_q;
    assign anabellek_adres_o    = adres_q;
    assign anabellek_oku_o      = oku_q;
    assign anabellek_yaz_o      = yaz_q;
    assign anabellek_yaz_obek_o = yaz_obek_q;
    assign durum_o              = durum_q;

endmodule

// File: tb/tb_anabellek_hakem.sv
// Self-checking bench for anabellek_hakem: directed scenarios plus randomized traffic
// against a transaction-level arbitration model.
module tb_anabellek_hakem;

    logic         clk;
    logic         rst_i;
    logic         b_istek_i;
    logic [31:0]  b_adres_i;
    logic         b_musait_o;
    logic         b_hazir_o;
    logic [127:0] b_obek_o;
    logic         v_istek_i;
    logic [31:0]  v_adres_i;
    logic         v_yaz_i;
    logic [127:0] v_yaz_obek_i;
    logic         v_musait_o;
    logic         v_hazir_o;
    logic [127:0] v_obek_o;
    logic         anabellek_musait_i;
    logic         anabellek_hazir_i;
    logic [127:0] anabellek_obek_i;
    logic         anabellek_istek_o;
    logic [31:0]  anabellek_adres_o;
    logic         anabellek_oku_o;
    logic         anabellek_yaz_o;
    logic [127:0] anabellek_yaz_obek_o;
    logic [1:0]   durum_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: last-served port (1 = data cache) and last block each port received.
    bit           m_son_v;
    logic [127:0] m_b_obek;
    logic [127:0] m_v_obek;
    logic [127:0] exp_q[$];

    anabellek_hakem dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .b_istek_i            (b_istek_i),
        .b_adres_i            (b_adres_i),
        .b_musait_o           (b_musait_o),
        .b_hazir_o            (b_hazir_o),
        .b_obek_o             (b_obek_o),
        .v_istek_i            (v_istek_i),
        .v_adres_i            (v_adres_i),
        .v_yaz_i              (v_yaz_i),
        .v_yaz_obek_i         (v_yaz_obek_i),
        .v_musait_o           (v_musait_o),
        .v_hazir_o            (v_hazir_o),
        .v_obek_o             (v_obek_o),
        .anabellek_musait_i   (anabellek_musait_i),
        .anabellek_hazir_i    (anabellek_hazir_i),
        .anabellek_obek_i     (anabellek_obek_i),
        .anabellek_istek_o    (anabellek_istek_o),
        .anabellek_adres_o    (anabellek_adres_o),
        .anabellek_oku_o      (anabellek_oku_o),
        .anabellek_yaz_o      (anabellek_yaz_o),
        .anabellek_yaz_obek_o (anabellek_yaz_obek_o),
        .durum_o              (durum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit model_grant_v(input bit bi, input bit vi);
        if (bi && vi) begin
`ifdef ANABELLEK_HAKEM_RR_EN
            return !m_son_v;
`else
            return 1'b1;
`endif
        end
        return vi;
    endfunction

    // Drives one complete transaction starting from an idle BOSTA cycle.
    task automatic run_txn(input bit bi, input bit vi, input bit vw,
                           input logic [31:0] ba, input logic [31:0] va,
                           input logic [127:0] wd, input logic [127:0] rd,
                           input int lat, input bit drop);
        bit           ev;
        bit           ew;
        logic [31:0]  ea;
        logic [127:0] got;
        ev = model_grant_v(bi, vi);
        ew = ev & vw;
        ea = ev ? {va[31:4], 4'h0} : {ba[31:4], 4'h0};

        b_istek_i = bi; b_adres_i = ba;
        v_istek_i = vi; v_adres_i = va; v_yaz_i = vw; v_yaz_obek_i = wd;
        anabellek_musait_i = 1'b1;
        #1;
        n_cmp++;
        if (b_musait_o !== 1'b1 || v_musait_o !== 1'b1) begin
            n_err++;
            $display("FAIL musait_idle: got b=%b v=%b required 1 1", b_musait_o, v_musait_o);
        end
        step();
        m_son_v = ev;

        n_cmp++;
        if (anabellek_istek_o !== 1'b1 || durum_o !== 2'd1) begin
            n_err++;
            $display("FAIL grant_istek: got istek=%b durum=%0d required 1 1", anabellek_istek_o, durum_o);
        end
        n_cmp++;
        if (anabellek_adres_o !== ea) begin
            n_err++;
            $display("FAIL grant_adres: got %h required %h", anabellek_adres_o, ea);
        end
        n_cmp++;
        if (anabellek_yaz_o !== ew || anabellek_oku_o !== !ew) begin
            n_err++;
            $display("FAIL grant_strobe: got oku=%b yaz=%b required oku=%b yaz=%b",
                     anabellek_oku_o, anabellek_yaz_o, !ew, ew);
        end
        if (ew) begin
            n_cmp++;
            if (anabellek_yaz_obek_o !== wd) begin
                n_err++;
                $display("FAIL grant_yaz_obek: got %h required %h", anabellek_yaz_obek_o, wd);
            end
        end
        n_cmp++;
        if (b_musait_o !== 1'b0 || v_musait_o !== 1'b0) begin
            n_err++;
            $display("FAIL musait_busy: got b=%b v=%b required 0 0", b_musait_o, v_musait_o);
        end

        if (drop) begin
            b_istek_i = 1'b0; v_istek_i = 1'b0;
            b_adres_i = ~ba; v_adres_i = ~va; v_yaz_i = ~vw; v_yaz_obek_i = ~wd;
        end

        for (int i = 1; i < lat; i++) begin
            step();
            n_cmp++;
            if (anabellek_istek_o !== 1'b1 || anabellek_adres_o !== ea ||
                anabellek_yaz_o !== ew || (ew && anabellek_yaz_obek_o !== wd)) begin
                n_err++;
                $display("FAIL hold_stable: got istek=%b adres=%h yaz=%b required 1 %h %b",
                         anabellek_istek_o, anabellek_adres_o, anabellek_yaz_o, ea, ew);
            end
        end

        anabellek_hazir_i = 1'b1;
        anabellek_obek_i  = rd;
        exp_q.push_back(rd);
        step();
        anabellek_hazir_i = 1'b0;
        anabellek_obek_i  = rand128();
        if (ev) m_v_obek = rd; else m_b_obek = rd;

        n_cmp++;
        if (b_hazir_o !== !ev || v_hazir_o !== ev) begin
            n_err++;
            $display("FAIL hazir_owner: got b=%b v=%b required b=%b v=%b", b_hazir_o, v_hazir_o, !ev, ev);
        end
        got = ev ? v_obek_o : b_obek_o;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else if (!ew) begin
            n_cmp++;
            if (got !== exp_q[0]) begin
                n_err++;
                $display("FAIL obek_owner: got %h required %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if ((ev ? b_obek_o : v_obek_o) !== (ev ? m_b_obek : m_v_obek)) begin
            n_err++;
            $display("FAIL obek_other: got %h required %h",
                     ev ? b_obek_o : v_obek_o, ev ? m_b_obek : m_v_obek);
        end
        n_cmp++;
        if (anabellek_istek_o !== 1'b0 || anabellek_oku_o !== 1'b0 ||
            anabellek_yaz_o !== 1'b0 || durum_o !== 2'd2) begin
            n_err++;
            $display("FAIL cevap_state: got istek=%b oku=%b yaz=%b durum=%0d required 0 0 0 2",
                     anabellek_istek_o, anabellek_oku_o, anabellek_yaz_o, durum_o);
        end

        step();
        n_cmp++;
        if (b_hazir_o !== 1'b0 || v_hazir_o !== 1'b0 || durum_o !== 2'd0) begin
            n_err++;
            $display("FAIL pulse_end: got b=%b v=%b durum=%0d required 0 0 0", b_hazir_o, v_hazir_o, durum_o);
        end
    endtask

    task automatic clear_inputs();
        b_istek_i = 1'b0; v_istek_i = 1'b0; v_yaz_i = 1'b0;
        anabellek_hazir_i = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (durum_o !== 2'd0 || b_hazir_o !== 1'b0 || v_hazir_o !== 1'b0 ||
            b_obek_o !== '0 || v_obek_o !== '0 || anabellek_istek_o !== 1'b0 ||
            anabellek_oku_o !== 1'b0 || anabellek_yaz_o !== 1'b0 ||
            anabellek_adres_o !== '0 || anabellek_yaz_obek_o !== '0) begin
            n_err++;
            $display("FAIL reset_values: got durum=%0d istek=%b adres=%h required all zero",
                     durum_o, anabellek_istek_o, anabellek_adres_o);
        end
        rst_i = 1'b1;
        m_son_v = 1'b1; m_b_obek = '0; m_v_obek = '0;
        step();
    endtask

    task automatic test_gating();
        anabellek_musait_i = 1'b0;
        b_istek_i = 1'b1; v_istek_i = 1'b1;
        #1;
        n_cmp++;
        if (b_musait_o !== 1'b0 || v_musait_o !== 1'b0) begin
            n_err++;
            $display("FAIL musait_mem_busy: got b=%b v=%b required 0 0", b_musait_o, v_musait_o);
        end
        step();
        n_cmp++;
        if (durum_o !== 2'd0 || anabellek_istek_o !== 1'b0) begin
            n_err++;
            $display("FAIL no_grant_busy: got durum=%0d istek=%b required 0 0", durum_o, anabellek_istek_o);
        end
        b_istek_i = 1'b0; v_istek_i = 1'b0;
        anabellek_hazir_i = 1'b1; anabellek_obek_i = rand128();
        step();
        anabellek_hazir_i = 1'b0;
        n_cmp++;
        if (b_hazir_o !== 1'b0 || v_hazir_o !== 1'b0 || durum_o !== 2'd0 ||
            b_obek_o !== m_b_obek || v_obek_o !== m_v_obek) begin
            n_err++;
            $display("FAIL hazir_in_bosta: got b=%b v=%b durum=%0d required 0 0 0", b_hazir_o, v_hazir_o, durum_o);
        end
    endtask

    task automatic test_icache_read();
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, '0, {16{8'hA5}}, 3, 1'b0);
        clear_inputs();
    endtask

    task automatic test_writeback();
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_004C,
                128'h0123456789ABCDEF0123456789ABCDEF, rand128(), 4, 1'b0);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        // Both ports hold their request across two grants.
        run_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, '0, rand128(), 2, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, '0, rand128(), 1, 1'b0);
        clear_inputs();
    endtask

    task automatic test_drop();
        run_txn(1'b1, 1'b0, 1'b0, 32'h4444_5558, 32'h0, '0, rand128(), 3, 1'b1);
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, rand128(), rand128(), 2, 1'b1);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        b_istek_i = 1'b1; b_adres_i = 32'h1111_2222; anabellek_musait_i = 1'b1;
        step();
        b_istek_i = 1'b0;
        #1 rst_i = 1'b0;
        #1;
        n_cmp++;
        if (durum_o !== 2'd0 || anabellek_istek_o !== 1'b0 || anabellek_oku_o !== 1'b0 ||
            anabellek_adres_o !== '0 || b_obek_o !== '0 || v_obek_o !== '0 ||
            anabellek_yaz_obek_o !== '0 || b_hazir_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got durum=%0d istek=%b adres=%h required 0 0 0",
                     durum_o, anabellek_istek_o, anabellek_adres_o);
        end
        step();
        rst_i = 1'b1;
        m_son_v = 1'b1; m_b_obek = '0; m_v_obek = '0;
        anabellek_hazir_i = 1'b1; anabellek_obek_i = rand128();
        step();
        anabellek_hazir_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (b_hazir_o !== 1'b0 || v_hazir_o !== 1'b0 || durum_o !== 2'd0 || b_obek_o !== '0) begin
                n_err++;
                $display("FAIL late_hazir: got b=%b v=%b durum=%0d required 0 0 0", b_hazir_o, v_hazir_o, durum_o);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], 1'($urandom_range(0, 1)), $urandom, $urandom,
                    rand128(), rand128(), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
            clear_inputs();
            if ($urandom_range(0, 2) == 0) step();
        end
    endtask

    initial begin
        rst_i = 1'b0;
        b_istek_i = 1'b0; b_adres_i = '0;
        v_istek_i = 1'b0; v_adres_i = '0; v_yaz_i = 1'b0; v_yaz_obek_i = '0;
        anabellek_musait_i = 1'b0; anabellek_hazir_i = 1'b0; anabellek_obek_i = '0;
        m_son_v = 1'b1; m_b_obek = '0; m_v_obek = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_gating();
        test_icache_read();
        test_writeback();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion required finish before 200000");
        $fatal(1);
    end

endmodule
